// File: rtl/word_serializer_pkg.sv
// Shared types and default widths for the wide-to-narrow word serializer.
// Contents:
//   ser_order_e  - beat ordering of a serialized word
//   AES_BLOCK_W  - default input word width (AES result block)
//   STREAM_W     - default output beat width (streamer sink)
package word_serializer_pkg;

  typedef enum logic {
    SER_LSB_FIRST = 1'b0,
    SER_MSB_FIRST = 1'b1
  } ser_order_e;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned STREAM_W    = 32;

endpackage

// File: rtl/word_serializer_stage.sv
// One word-wide holding register with a full flag.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   load_i        - capture data_i and mark full (wins over drop_i)
//   drop_i        - mark empty
//   data_i/data_o - word in / held word out
//   full_o        - a word is held
module word_serializer_stage
  import word_serializer_pkg::*;
#(
  parameter int unsigned W = AES_BLOCK_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         drop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] data_q;
  logic         full_q;

  // Load has priority so a drain and a refill can share one edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (drop_i) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/word_serializer.sv
// Wide-to-narrow stream serializer: IN_W-bit words in, IN_W/OUT_W beats of
// OUT_W bits out, with a last-beat flag. Outputs depend on held state and
// enable_i only; there is no path from out_ready_i to out_valid_o.
// Build option: define WORD_SERIALIZER_PREFETCH_EN to add a second word
// register so words stream back-to-back without an idle beat.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   clr_i                    - synchronous flush (beats precedence over enable_i)
//   enable_i                 - 0 freezes state and idles both handshakes
//   in_valid_i/in_ready_o    - input word handshake, in_data_i word
//   out_valid_o/out_ready_i  - output beat handshake, out_data_o beat
//   out_last_o               - final beat of a word
//   busy_o                   - any word held
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned IN_W      = AES_BLOCK_W,
  parameter int unsigned OUT_W     = STREAM_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             enable_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int unsigned NBEATS = (OUT_W == 0) ? 1 : IN_W / OUT_W;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);
  localparam ser_order_e ORDER = MSB_FIRST ? SER_MSB_FIRST : SER_LSB_FIRST;

  if ((OUT_W == 0) || (IN_W < OUT_W) || ((IN_W % OUT_W) != 0)) begin : g_bad_width
    $error("word_serializer: IN_W must be a non-zero integer multiple of OUT_W");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] beat_idx;
  logic [IN_W-1:0]  act_data, act_load_data, shifted;
  logic             act_full, act_load, act_drop;
  logic             accept, fire_out, last_beat, fire_last;

  assign last_beat   = (cnt_q == LAST_CNT);
  assign out_valid_o = enable_i & act_full;
  assign out_last_o  = out_valid_o & last_beat;
  assign fire_out    = out_valid_o & out_ready_i;
  assign fire_last   = fire_out & last_beat;
  assign accept      = in_valid_i & in_ready_o;
  assign act_drop    = clr_i | fire_last;

  // in_ready_o is also low while clr_i is high so no word is accepted into a flush.
`ifdef WORD_SERIALIZER_PREFETCH_EN
  logic [IN_W-1:0] pf_data;
  logic            pf_full, pf_load, pf_drop;

  assign in_ready_o    = enable_i & ~clr_i & ~pf_full;
  // Active refills on its last beat from prefetch, else from a word presented now.
  assign act_load      = ~clr_i & ((fire_last & pf_full) | (accept & (~act_full | fire_last)));
  assign act_load_data = pf_full ? pf_data : in_data_i;
  assign pf_load       = ~clr_i & accept & act_full & ~fire_last;
  assign pf_drop       = clr_i | (fire_last & pf_full);
  assign busy_o        = act_full | pf_full;

  word_serializer_stage #(.W(IN_W)) u_prefetch (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (pf_load),
    .drop_i (pf_drop),
    .data_i (in_data_i),
    .data_o (pf_data),
    .full_o (pf_full)
  );
`else
  assign in_ready_o    = enable_i & ~clr_i & ~act_full;
  assign act_load      = ~clr_i & accept;
  assign act_load_data = in_data_i;
  assign busy_o        = act_full;
`endif

  word_serializer_stage #(.W(IN_W)) u_active (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (act_load),
    .drop_i (act_drop),
    .data_i (act_load_data),
    .data_o (act_data),
    .full_o (act_full)
  );

  // Beat counter: advances only on a transfer, wraps after the last beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (fire_out) begin
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Beat select: MSB-first walks the slices from the top of the word down.
  assign beat_idx   = (ORDER == SER_MSB_FIRST) ? (LAST_CNT - cnt_q) : cnt_q;
  assign shifted    = act_data >> (OUT_W * 32'(beat_idx));
  assign out_data_o = out_valid_o ? shifted[OUT_W-1:0] : '0;

endmodule
